// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder and its RAM.
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dm_state_e;

  localparam logic [3:0] BE_ALL = 4'b1111;
  localparam int         CNT_W  = 4;

endpackage

// File: rtl/dm_responder_if.sv
// Request/response bus between the MEM stage (master) and dm_responder (slave).
interface dm_responder_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  // A request transfers on a rising edge where req_valid & req_ready; the master
  // holds its request fields stable while req_valid is high and ready is low.
  // rsp_valid is a single-cycle pulse with no back-pressure; rsp_err is only
  // meaningful while rsp_valid is high.
  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [3:0]        req_be;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dm_ram.sv
// DEPTH x 32 synchronous data array: byte-enable write, registered read.
// Out-of-range accesses write nothing and read back zero.
module dm_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        be,
  output logic [DATA_W-1:0] rdata
);
  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              in_range;

  assign idx      = addr[IDX_W-1:0];
  assign in_range = {1'b0, addr} < DEPTH_L;

  // The array itself is never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (en && we && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= in_range ? mem[idx] : '0;
    end
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: one request at a time, fixed access latency, one-cycle
// response pulse. Define DM_RESP_ERR_EN to enable the rsp_err detection logic.
module dm_responder
  import dm_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic           clk,
  input  logic           rst,
  dm_responder_if.slave  bus,
  output logic           busy,
  output dm_state_e      state_dbg
);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  dm_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              accept;
  logic              access;

  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [3:0]        cap_be;

  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [3:0]        acc_be;

  assign accept = bus.req_valid && (state_q == IDLE);

  // With LATENCY = 1 the accepting edge is also the access edge, so the RAM
  // must see the live request fields rather than the captured copy.
  always_comb begin
    state_d   = state_q;
    access    = 1'b0;
    acc_we    = cap_we;
    acc_addr  = cap_addr;
    acc_wdata = cap_wdata;
    acc_be    = cap_be;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d   = RESP;
            access    = 1'b1;
            acc_we    = bus.req_we;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
            acc_be    = bus.req_be;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          access  = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept)                cnt_q <= LAT_M1;
      else if (state_q == WAIT)  cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cap_we    <= bus.req_we;
      cap_addr  <= bus.req_addr;
      cap_wdata <= bus.req_wdata;
      cap_be    <= bus.req_be;
    end
  end

  // Reset wins over a coincident access edge, so an uncommitted store is dropped.
  dm_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .en    (access && !rst),
    .we    (acc_we),
    .addr  (acc_addr),
    .wdata (acc_wdata),
    .be    (acc_be),
    .rdata (bus.rsp_rdata)
  );

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign busy          = (state_q != IDLE);
  assign state_dbg     = state_q;

`ifdef DM_RESP_ERR_EN
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (access) begin
      err_q <= ({1'b0, acc_addr} >= DEPTH_L) || (acc_we && (acc_be == 4'b0000));
    end
  end

  assign bus.rsp_err = (state_q == RESP) && err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: one LATENCY=2/DEPTH=1024 instance and one
// LATENCY=1/DEPTH=512 instance sharing clock and reset.
module tb_dm_responder;
  import dm_pkg::*;

`ifdef DM_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic      clk;
  logic      rst;
  logic      busy0, busy1;
  dm_state_e st0, st1;

  dm_responder_if #(.ADDR_W(10), .DATA_W(32)) b0 ();
  dm_responder_if #(.ADDR_W(10), .DATA_W(32)) b1 ();

  dm_responder #(.ADDR_W(10), .DATA_W(32), .DEPTH(1024), .LATENCY(2)) u0 (
    .clk(clk), .rst(rst), .bus(b0), .busy(busy0), .state_dbg(st0)
  );

  dm_responder #(.ADDR_W(10), .DATA_W(32), .DEPTH(512), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .bus(b1), .busy(busy1), .state_dbg(st1)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic drive(input bit s, input bit v, input bit we, input logic [9:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    if (s) begin
      b1.req_valid = v; b1.req_we = we; b1.req_addr = addr; b1.req_wdata = wdata; b1.req_be = be;
    end else begin
      b0.req_valid = v; b0.req_we = we; b0.req_addr = addr; b0.req_wdata = wdata; b0.req_be = be;
    end
  endtask

  function automatic logic get_ready(input bit s);  return s ? b1.req_ready : b0.req_ready; endfunction
  function automatic logic get_valid(input bit s);  return s ? b1.rsp_valid : b0.rsp_valid; endfunction
  function automatic logic get_err(input bit s);    return s ? b1.rsp_err   : b0.rsp_err;   endfunction
  function automatic logic get_busy(input bit s);   return s ? busy1        : busy0;        endfunction
  function automatic logic [31:0] get_rdata(input bit s); return s ? b1.rsp_rdata : b0.rsp_rdata; endfunction

  // One full transaction: present at a negedge, accept on the next rising edge,
  // then count negedges until the response pulse is seen.
  task automatic do_req(input bit s, input bit we, input logic [9:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int busy_n, output bit pulse_ok);
    int  n;
    bit  seen;
    @(negedge clk);
    drive(s, 1'b1, we, addr, wdata, be);
    n = 0;
    while (!get_ready(s) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_accept", {31'd0, get_ready(s)}, 32'd1);
    @(posedge clk);
    #1;
    drive(s, 1'b0, 1'b0, 10'd0, 32'd0, 4'd0);
    lat = 0; busy_n = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (get_busy(s))  busy_n++;
      if (get_valid(s)) seen = 1'b1;
    end
    rdata = get_rdata(s);
    err   = get_err(s);
    @(negedge clk);
    pulse_ok = seen && !get_valid(s) && !get_busy(s);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          sel;
    bit          we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  localparam int NV = 17;
  vec_t vec[NV];

  logic [31:0] rd;
  logic        er;
  int          lt, bn, got, issued, last, rcnt;
  bit          pk, acc;

  initial begin
    vec[0]  = '{0, 1, 10'h010, 32'hDEADBEEF, BE_ALL,  32'h00000000, 1'b0,   2};
    vec[1]  = '{0, 0, 10'h010, 32'h00000000, 4'h0,    32'hDEADBEEF, 1'b0,   2};
    vec[2]  = '{0, 1, 10'h005, 32'h11223344, BE_ALL,  32'hDEADBEEF, 1'b0,   2};
    vec[3]  = '{0, 1, 10'h005, 32'hAABBCCDD, 4'b0101, 32'hDEADBEEF, 1'b0,   2};
    vec[4]  = '{0, 0, 10'h005, 32'h00000000, 4'h0,    32'h11BB33DD, 1'b0,   2};
    vec[5]  = '{0, 1, 10'h3FF, 32'hCAFEF00D, BE_ALL,  32'h11BB33DD, 1'b0,   2};
    vec[6]  = '{0, 0, 10'h3FF, 32'h00000000, 4'h0,    32'hCAFEF00D, 1'b0,   2};
    vec[7]  = '{1, 0, 10'h200, 32'h00000000, 4'h0,    32'h00000000, ERR_EN, 1};
    vec[8]  = '{1, 1, 10'h020, 32'h55667788, BE_ALL,  32'h00000000, 1'b0,   1};
    vec[9]  = '{1, 1, 10'h020, 32'hFFFFFFFF, 4'h0,    32'h00000000, ERR_EN, 1};
    vec[10] = '{1, 0, 10'h020, 32'h00000000, 4'h0,    32'h55667788, 1'b0,   1};
    vec[11] = '{1, 1, 10'h1FF, 32'h0BADF00D, BE_ALL,  32'h55667788, 1'b0,   1};
    vec[12] = '{1, 0, 10'h1FF, 32'h00000000, 4'h0,    32'h0BADF00D, 1'b0,   1};
    vec[13] = '{1, 1, 10'h000, 32'h01020304, BE_ALL,  32'h0BADF00D, 1'b0,   1};
    vec[14] = '{1, 1, 10'h200, 32'h12345678, BE_ALL,  32'h0BADF00D, ERR_EN, 1};
    vec[15] = '{1, 0, 10'h200, 32'h00000000, 4'h0,    32'h00000000, ERR_EN, 1};
    vec[16] = '{1, 0, 10'h000, 32'h00000000, 4'h0,    32'h01020304, 1'b0,   1};

    // ---- reset then idle ----
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 10'd0, 32'd0, 4'd0);
    drive(1, 1'b0, 1'b0, 10'd0, 32'd0, 4'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst_ready%0d", s), {31'd0, get_ready(s[0])}, 32'd1);
      chk($sformatf("rst_valid%0d", s), {31'd0, get_valid(s[0])}, 32'd0);
      chk($sformatf("rst_busy%0d",  s), {31'd0, get_busy(s[0])},  32'd0);
      chk($sformatf("rst_rdata%0d", s), get_rdata(s[0]),           32'd0);
      chk($sformatf("rst_err%0d",   s), {31'd0, get_err(s[0])},   32'd0);
    end
    chk("rst_state0", {30'd0, st0}, {30'd0, IDLE});

    // ---- table-driven transactions ----
    for (int i = 0; i < NV; i++) begin
      do_req(vec[i].sel, vec[i].we, vec[i].addr, vec[i].wdata, vec[i].be, rd, er, lt, bn, pk);
      chk($sformatf("v%0d_rdata", i), rd, vec[i].exp_rdata);
      chk($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, vec[i].exp_err});
      chk($sformatf("v%0d_lat", i), lt, vec[i].exp_lat);
      chk($sformatf("v%0d_busy_cycles", i), bn, vec[i].exp_lat);
      chk($sformatf("v%0d_pulse", i), {31'd0, pk}, 32'd1);
    end

    // ---- LATENCY=1, req_valid held high across four loads ----
    for (int i = 0; i < 4; i++) begin
      do_req(1, 1'b1, 10'(32'h40 + i), 32'hA0A0_0000 + i, BE_ALL, rd, er, lt, bn, pk);
      exp_q.push_back(32'hA0A0_0000 + i);
    end
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 10'h040, 32'd0, 4'd0);
    got = 0; issued = 0; last = -1;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      if (b1.rsp_valid) begin
        if (exp_q.size() > 0) chk($sformatf("b2b_rdata%0d", got), b1.rsp_rdata, exp_q.pop_front());
        if (last >= 0) chk($sformatf("b2b_gap%0d", got), cyc - last, 2);
        last = cyc;
        got++;
      end
      acc = b1.req_ready && b1.req_valid;
      @(posedge clk);
      #1;
      if (acc) begin
        issued++;
        if (issued < 4) b1.req_addr = 10'(32'h40 + issued);
        else            b1.req_valid = 1'b0;
      end
      @(negedge clk);
    end
    repeat (4) begin
      @(negedge clk);
      if (b1.rsp_valid) got++;
    end
    chk("b2b_responses", got, 4);
    chk("b2b_accepts", issued, 4);

    // ---- reset during WAIT of a store ----
    do_req(0, 1'b1, 10'h007, 32'h00000000, BE_ALL, rd, er, lt, bn, pk);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 10'h007, 32'h99999999, BE_ALL);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 10'd0, 32'd0, 4'd0);
    @(negedge clk);
    chk("midrst_in_wait", {30'd0, st0}, {30'd0, WAIT});
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rcnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (b0.rsp_valid) rcnt++;
    end
    chk("midrst_no_rsp", rcnt, 0);
    chk("midrst_busy", {31'd0, busy0}, 32'd0);
    do_req(0, 1'b0, 10'h007, 32'd0, 4'd0, rd, er, lt, bn, pk);
    chk("midrst_load7", rd, 32'h00000000);
    chk("midrst_load7_lat", lt, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
